// File: rtl/irq_plic.sv
// rtl/irq_plic.sv - platform-level interrupt controller with claim/complete handshake
module irq_plic #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_wr_i,
  output logic [31:0]        data_rd_o,
  output logic               rd_valid_o,
  output logic               ext_irq_o
);

  typedef logic [PRIO_W-1:0] prio_t;

  prio_t              prio_q [1:NUM_SRC];
  prio_t              prio_d [1:NUM_SRC];
  logic [NUM_SRC:1]   enable_q, enable_d;
  logic [NUM_SRC:1]   edge_mode_q, edge_mode_d;
  prio_t              thresh_q, thresh_d;
  logic [NUM_SRC:1]   pending_q, pending_d;
  logic [NUM_SRC:1]   in_service_q, in_service_d;
  logic [NUM_SRC:1]   sync1_q, sync2_q, sync3_q;
  logic [4:0]         best_id_q, best_id_d;
  prio_t              best_prio_q, best_prio_d;
  logic [31:0]        data_rd_q, rd_data_d;
  logic               rd_valid_q, ext_irq_q;

  logic [5:0] word;
  logic       wr_ok, claim, complete;
  logic       unused_ok;

  // A read wins over a simultaneous write; claim only has side effects with a live winner
  assign word     = addr_i[7:2];
  assign wr_ok    = wr_en_i && !rd_en_i;
  assign claim    = rd_en_i && (word == 6'd36) && (best_id_q != 5'd0);
  assign complete = wr_ok && (word == 6'd36);
  assign unused_ok = ^{addr_i[1:0], best_prio_q};

  // Register-file writes, truncated to each field's width
  always_comb begin
    prio_d      = prio_q;
    enable_d    = enable_q;
    edge_mode_d = edge_mode_q;
    thresh_d    = thresh_q;
    if (wr_ok) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (word == 6'(i)) prio_d[i] = data_wr_i[PRIO_W-1:0];
      end
      case (word)
        6'd33:   enable_d    = data_wr_i[NUM_SRC:1];
        6'd34:   edge_mode_d = data_wr_i[NUM_SRC:1];
        6'd35:   thresh_d    = data_wr_i[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Gateway sets pending; claim clears it afterwards so claim wins the same-edge race
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!pending_q[i] && !in_service_q[i] &&
          (edge_mode_q[i] ? (sync2_q[i] && !sync3_q[i]) : sync2_q[i]))
        pending_d[i] = 1'b1;
      if (complete && (data_wr_i == 32'(i)))
        in_service_d[i] = 1'b0;
      if (claim && (best_id_q == 5'(i))) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
    end
  end

  // Arbiter: scan from the top ID down so >= lets the lowest ID win ties
  always_comb begin
    best_id_d   = 5'd0;
    best_prio_d = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > thresh_q) &&
          (prio_q[i] >= best_prio_d)) begin
        best_id_d   = 5'(i);
        best_prio_d = prio_q[i];
      end
    end
  end

  // Read mux; bit 0 of the per-source vectors is the unused ID 0
  always_comb begin
    rd_data_d = 32'd0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (word == 6'(i)) rd_data_d = 32'(prio_q[i]);
    end
    case (word)
      6'd32:   rd_data_d = 32'({pending_q, 1'b0});
      6'd33:   rd_data_d = 32'({enable_q, 1'b0});
      6'd34:   rd_data_d = 32'({edge_mode_q, 1'b0});
      6'd35:   rd_data_d = 32'(thresh_q);
      6'd36:   rd_data_d = 32'(best_id_q);
      default: ;
    endcase
  end

  // State registers, synchroniser and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
      enable_q     <= '0;
      edge_mode_q  <= '0;
      thresh_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      best_id_q    <= '0;
      best_prio_q  <= '0;
      data_rd_q    <= '0;
      rd_valid_q   <= 1'b0;
      ext_irq_q    <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      enable_q     <= enable_d;
      edge_mode_q  <= edge_mode_d;
      thresh_q     <= thresh_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      sync1_q      <= irq_src_i;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      best_id_q    <= best_id_d;
      best_prio_q  <= best_prio_d;
      if (rd_en_i) data_rd_q <= rd_data_d;
      rd_valid_q   <= rd_en_i;
      ext_irq_q    <= (best_id_d != 5'd0);
    end
  end

  assign data_rd_o  = data_rd_q;
  assign rd_valid_o = rd_valid_q;
  assign ext_irq_o  = ext_irq_q;

endmodule

// File: tb/tb_irq_plic.sv
// tb/tb_irq_plic.sv - directed self-checking bench for irq_plic
module tb_irq_plic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        wr_en, rd_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] data_rd;
  logic        rd_valid, ext_irq;
  logic [31:0] d;
  int          checks = 0;
  int          errors = 0;

  irq_plic #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_src_i  (irq_src),
    .wr_en_i    (wr_en),
    .rd_en_i    (rd_en),
    .addr_i     (addr),
    .data_wr_i  (wdata),
    .data_rd_o  (data_rd),
    .rd_valid_o (rd_valid),
    .ext_irq_o  (ext_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] v);
    wr_en = 1'b1; addr = a; wdata = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] v);
    rd_en = 1'b1; addr = a;
    tick();
    v = data_rd;
    check("rd_valid", {31'd0, rd_valid}, 32'd1);
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; irq_src = '0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    ticks(2);
    check("rst_ext_irq", {31'd0, ext_irq}, 32'd0);
    check("rst_data_rd", data_rd, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Field masking and unmapped addresses
    reg_wr(8'h84, 32'hFFFF_FFFF); reg_rd(8'h84, d); check("enable_mask", d, 32'h1FE);
    reg_wr(8'h88, 32'hFFFF_FFFF); reg_rd(8'h88, d); check("edge_mask", d, 32'h1FE);
    reg_wr(8'h88, 32'h0); reg_wr(8'h84, 32'h0);
    reg_rd(8'h00, d); check("rd_reserved", d, 32'h0);
    reg_rd(8'hFC, d); check("rd_unmapped", d, 32'h0);
    reg_wr(8'h04, 32'hFF); reg_rd(8'h04, d); check("prio_trunc", d, 32'h7);
    reg_wr(8'h8C, 32'hFFFF); reg_rd(8'h8C, d); check("thresh_trunc", d, 32'h7);
    reg_wr(8'h8C, 32'h0);
    tick();
    check("rd_valid_low", {31'd0, rd_valid}, 32'd0);
    check("data_rd_hold", data_rd, 32'h7);
    reg_wr(8'h04, 32'h0);

    // Read and write together: read wins, write dropped
    rd_en = 1'b1; wr_en = 1'b1; addr = 8'h84; wdata = 32'hFF;
    tick();
    check("rdwr_data", data_rd, 32'h0);
    rd_en = 1'b0; wr_en = 1'b0;
    reg_rd(8'h84, d); check("rdwr_enable_kept", d, 32'h0);

    // Level source 3: latency, claim, complete with line still high
    reg_wr(8'h0C, 32'd2); reg_wr(8'h84, 32'h08);
    irq_src[2] = 1'b1;
    ticks(3);
    check("lvl_ext_n2", {31'd0, ext_irq}, 32'd0);
    tick();
    check("lvl_ext_n3", {31'd0, ext_irq}, 32'd1);
    reg_rd(8'h80, d); check("lvl_pending", d, 32'h08);
    reg_rd(8'h90, d); check("lvl_claim", d, 32'd3);
    tick();
    check("lvl_ext_after_claim", {31'd0, ext_irq}, 32'd0);
    reg_rd(8'h80, d); check("lvl_pending_claimed", d, 32'h0);
    reg_wr(8'h90, 32'd3);
    tick();
    check("lvl_repend_c1", {31'd0, ext_irq}, 32'd0);
    tick();
    check("lvl_repend_c2", {31'd0, ext_irq}, 32'd1);
    irq_src[2] = 1'b0;
    reg_rd(8'h90, d); check("lvl_reclaim", d, 32'd3);
    ticks(3);
    reg_wr(8'h90, 32'd3);
    ticks(4);
    reg_rd(8'h80, d); check("lvl_idle_pending", d, 32'h0);
    check("lvl_idle_ext", {31'd0, ext_irq}, 32'd0);
    reg_wr(8'h84, 32'h0);

    // Priority ordering and tie-break
    reg_wr(8'h08, 32'd4); reg_wr(8'h14, 32'd6); reg_wr(8'h84, 32'h24);
    irq_src[1] = 1'b1; irq_src[4] = 1'b1;
    ticks(4);
    irq_src = '0;
    reg_rd(8'h80, d); check("prio_pending", d, 32'h24);
    reg_rd(8'h90, d); check("prio_claim_hi", d, 32'd5);
    tick();
    reg_rd(8'h90, d); check("prio_claim_lo", d, 32'd2);
    tick();
    reg_rd(8'h80, d); check("prio_pending_clr", d, 32'h0);
    reg_wr(8'h90, 32'd5); reg_wr(8'h90, 32'd2);
    ticks(3);
    reg_wr(8'h14, 32'd4);
    irq_src[1] = 1'b1; irq_src[4] = 1'b1;
    ticks(4);
    irq_src = '0;
    reg_rd(8'h90, d); check("tie_claim", d, 32'd2);
    tick();
    reg_wr(8'h90, 32'd2);
    reg_wr(8'h8C, 32'd4);
    tick();
    check("thresh_ext", {31'd0, ext_irq}, 32'd0);
    reg_rd(8'h90, d); check("thresh_claim", d, 32'd0);
    reg_rd(8'h80, d); check("thresh_pending_kept", d, 32'h20);
    reg_wr(8'h8C, 32'd0);
    tick();
    check("thresh_off_ext", {31'd0, ext_irq}, 32'd1);
    reg_rd(8'h90, d); check("thresh_off_claim", d, 32'd5);
    tick();
    reg_wr(8'h90, 32'd5); reg_wr(8'h84, 32'h0);

    // Edge mode source 1, bogus completes, dropped edges
    reg_wr(8'h88, 32'h02); reg_wr(8'h04, 32'd1); reg_wr(8'h84, 32'h02);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    ticks(3);
    reg_rd(8'h80, d); check("edge_pending", d, 32'h02);
    reg_rd(8'h90, d); check("edge_claim", d, 32'd1);
    reg_wr(8'h90, 32'd0); reg_wr(8'h90, 32'd9); reg_wr(8'h90, 32'd2);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    ticks(3);
    reg_rd(8'h80, d); check("edge_bogus_cpl", d, 32'h0);
    reg_wr(8'h90, 32'd1);
    ticks(3);
    reg_rd(8'h80, d); check("edge_dropped", d, 32'h0);
    check("edge_dropped_ext", {31'd0, ext_irq}, 32'd0);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    ticks(3);
    reg_rd(8'h80, d); check("edge_repulse", d, 32'h02);
    tick();
    check("edge_ext", {31'd0, ext_irq}, 32'd1);

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("arst_ext", {31'd0, ext_irq}, 32'd0);
    check("arst_data", data_rd, 32'd0);
    check("arst_valid", {31'd0, rd_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    reg_rd(8'h80, d); check("arst_pending", d, 32'h0);
    check("arst_ext_after", {31'd0, ext_irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
